// File: rtl/traffic_cmd_parser.sv
// traffic_cmd_parser: framed byte-stream command parser feeding the traffic-light
// controller. Validates sync/type (and optionally a trailing XOR checksum), issues
// one cmd_valid_o strobe per good frame, then holds off input for GAP_CYC cycles.
// Stalled or malformed frames are dropped with a one-cycle err_o pulse.
//
// Optional feature: define TRAFFIC_CMD_PARSER_CHECKSUM_EN to require a trailing
// checksum byte (XOR of all preceding frame bytes) on every frame.
//
// Ports:
//   clk_i, srst_i              clock, synchronous active-high reset
//   byte_i, byte_valid_i       input byte stream
//   byte_ready_o               parser can accept a byte (combinational)
//   cmd_type_o, cmd_data_o     last issued command (registered, held)
//   cmd_valid_o                one-cycle command strobe
//   err_o, err_code_o          one-cycle error strobe and code
//                              (0 sync, 1 type, 2 timeout, 3 checksum)
module traffic_cmd_parser #(
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [2:0]  cmd_type_o,
  output logic [15:0] cmd_data_o,
  output logic        cmd_valid_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_LAST);

  localparam logic [1:0] ERR_SYNC    = 2'd0;
  localparam logic [1:0] ERR_TYPE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM    = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA_HI,
    S_DATA_LO,
    S_ISSUE,
    S_GAP
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t        state;
  logic [2:0]    type_q;
  logic [7:0]    data_hi_q;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_inc;
  logic [GW-1:0] gap_cnt;
  logic          xfer;
  logic          hdr_bad_sync;
  logic          hdr_bad_type;
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
  logic [7:0]    data_lo_q;
  logic [7:0]    csum_q;
`endif

  // Ready only in byte-collecting states, and never while reset is asserted.
  always_comb begin
    byte_ready_o = 1'b0;
    case (state)
      S_IDLE, S_DATA_HI, S_DATA_LO: byte_ready_o = 1'b1;
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
      S_CSUM:                       byte_ready_o = 1'b1;
`endif
      default:                      byte_ready_o = 1'b0;
    endcase
    if (srst_i) byte_ready_o = 1'b0;
  end

  assign xfer         = byte_valid_i && byte_ready_o;
  assign hdr_bad_sync = (byte_i[7:4] != 4'hA) || byte_i[3];
  assign hdr_bad_type = (byte_i[2:0] > 3'd5);
  // Saturating increment so the counter can never wrap.
  assign to_cnt_inc   = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TW'(1);

  // Frame FSM with registered strobes and command outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= S_IDLE;
      type_q      <= 3'd0;
      data_hi_q   <= 8'd0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      cmd_type_o  <= 3'd0;
      cmd_data_o  <= 16'd0;
      cmd_valid_o <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= 2'd0;
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
      data_lo_q   <= 8'd0;
      csum_q      <= 8'd0;
`endif
    end else begin
      cmd_valid_o <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if (hdr_bad_sync) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_SYNC;
            end else if (hdr_bad_type) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_TYPE;
            end else begin
              type_q <= byte_i[2:0];
              to_cnt <= '0;
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
              csum_q    <= byte_i;
              data_hi_q <= 8'd0;
              data_lo_q <= 8'd0;
              state     <= (byte_i[2:0] >= 3'd3) ? S_DATA_HI : S_CSUM;
`else
              if (byte_i[2:0] >= 3'd3) begin
                state <= S_DATA_HI;
              end else begin
                state       <= S_ISSUE;
                cmd_valid_o <= 1'b1;
                cmd_type_o  <= byte_i[2:0];
                cmd_data_o  <= 16'd0;
              end
`endif
            end
          end
        end

        S_DATA_HI: begin
          if (xfer) begin
            data_hi_q <= byte_i;
            to_cnt    <= '0;
            state     <= S_DATA_LO;
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
            csum_q    <= csum_q ^ byte_i;
`endif
          end else begin
            to_cnt <= to_cnt_inc;
            if (to_cnt_inc == TO_MAX) begin
              state      <= S_IDLE;
              to_cnt     <= '0;
              err_o      <= 1'b1;
              err_code_o <= ERR_TIMEOUT;
            end
          end
        end

        S_DATA_LO: begin
          if (xfer) begin
            to_cnt <= '0;
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
            data_lo_q <= byte_i;
            csum_q    <= csum_q ^ byte_i;
            state     <= S_CSUM;
`else
            state       <= S_ISSUE;
            cmd_valid_o <= 1'b1;
            cmd_type_o  <= type_q;
            cmd_data_o  <= {data_hi_q, byte_i};
`endif
          end else begin
            to_cnt <= to_cnt_inc;
            if (to_cnt_inc == TO_MAX) begin
              state      <= S_IDLE;
              to_cnt     <= '0;
              err_o      <= 1'b1;
              err_code_o <= ERR_TIMEOUT;
            end
          end
        end

`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            to_cnt <= '0;
            if (byte_i == csum_q) begin
              state       <= S_ISSUE;
              cmd_valid_o <= 1'b1;
              cmd_type_o  <= type_q;
              cmd_data_o  <= {data_hi_q, data_lo_q};
            end else begin
              state      <= S_IDLE;
              err_o      <= 1'b1;
              err_code_o <= ERR_CSUM;
            end
          end else begin
            to_cnt <= to_cnt_inc;
            if (to_cnt_inc == TO_MAX) begin
              state      <= S_IDLE;
              to_cnt     <= '0;
              err_o      <= 1'b1;
              err_code_o <= ERR_TIMEOUT;
            end
          end
        end
`endif

        S_ISSUE: begin
          gap_cnt <= '0;
          state   <= (GAP_CYC > 0) ? S_GAP : S_IDLE;
        end

        S_GAP: begin
          if (gap_cnt == GAP_END) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_cmd_parser.sv
// tb_traffic_cmd_parser: directed self-checking bench for traffic_cmd_parser.
// Frames are built by the bench (with a trailing XOR byte when
// TRAFFIC_CMD_PARSER_CHECKSUM_EN is defined) and results compared to
// hand-computed constants.
module tb_traffic_cmd_parser;

  localparam int unsigned GAP     = 4;
  localparam int unsigned TIMEOUT = 1000;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [2:0]  cmd_type_o;
  logic [15:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  traffic_cmd_parser #(.GAP_CYC(GAP), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .cmd_type_o   (cmd_type_o),
    .cmd_data_o   (cmd_data_o),
    .cmd_valid_o  (cmd_valid_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Command and error strobes must be mutually exclusive.
  always @(negedge clk_i) begin
    if (cmd_valid_o && err_o) check("excl", 32'd1, 32'd0);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one byte until accepted; acc is the cycle index of the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("accept_wait", 32'd0, 32'd1);
    step();
    acc          = cyc;
    byte_valid_i = 1'b0;
  endtask

  // Send a well-formed frame; returns accept cycles of its first and last bytes.
  task automatic send_frame(input logic [2:0] t, input logic [15:0] d,
                            output int first, output int last);
    logic [7:0] q[$];
    logic [7:0] x;
    int a;
    q.push_back({4'hA, 1'b0, t});
    if (t >= 3'd3) begin
      q.push_back(d[15:8]);
      q.push_back(d[7:0]);
    end
`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`else
    x = 8'h00;
`endif
    first = 0;
    foreach (q[i]) begin
      send_byte(q[i], a);
      if (i == 0) first = a;
    end
    last = a;
  endtask

  initial begin
    int a0, a1, f0, l0, low, n;

    // Reset state.
    step(); step();
    check("rst_ready", 32'(byte_ready_o), 32'd0);
    srst_i = 1'b0;
    #1;
    check("rst_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_err",   32'(err_o),       32'd0);
    check("rst_code",  32'(err_code_o),  32'd0);
    check("rst_type",  32'(cmd_type_o),  32'd0);
    check("rst_data",  32'(cmd_data_o),  32'd0);
    check("rst_ready_rel", 32'(byte_ready_o), 32'd1);

    // Short frame type 0, ready low for 1+GAP cycles.
    send_frame(3'd0, 16'h0000, f0, l0);
    check("t0_valid", 32'(cmd_valid_o), 32'd1);
    check("t0_type",  32'(cmd_type_o),  32'd0);
    check("t0_data",  32'(cmd_data_o),  32'd0);
    check("t0_err",   32'(err_o),       32'd0);
    low = 0;
    while (!byte_ready_o && low < 50) begin
      low++;
      step();
      if (low == 1) check("t0_valid_1cyc", 32'(cmd_valid_o), 32'd0);
    end
    check("t0_ready_low", 32'(low), 32'(1 + GAP));

    // Long frame type 3 and back-to-back pacing.
    send_frame(3'd3, 16'h000A, f0, l0);
    check("t3_valid", 32'(cmd_valid_o), 32'd1);
    check("t3_type",  32'(cmd_type_o),  32'd3);
    check("t3_data",  32'(cmd_data_o),  32'h000A);
    a0 = l0;
    send_frame(3'd0, 16'h0000, f0, l0);
    check("gap_spacing", 32'(f0 - a0), 32'(2 + GAP));
    check("t0b_type", 32'(cmd_type_o), 32'd0);
    check("t0b_data", 32'(cmd_data_o), 32'd0);

    // Bad sync then bad type: no gap after errors.
    send_byte(8'h53, a0);
    check("sync_err",   32'(err_o),       32'd1);
    check("sync_code",  32'(err_code_o),  32'd0);
    check("sync_valid", 32'(cmd_valid_o), 32'd0);
    send_byte(8'hA7, a1);
    check("err_nogap",  32'(a1 - a0),     32'd1);
    check("type_err",   32'(err_o),       32'd1);
    check("type_code",  32'(err_code_o),  32'd1);
    check("type_valid", 32'(cmd_valid_o), 32'd0);
    step();
    check("err_1cyc", 32'(err_o), 32'd0);

    // Timeout inside a long frame, then a normal type 1 frame.
    send_byte(8'hA4, a0);
    send_byte(8'h12, a0);
    n = 0;
    while (!err_o && n < 2 * TIMEOUT) begin
      step();
      n++;
    end
    check("to_latency", 32'(cyc - a0), 32'(TIMEOUT));
    check("to_code",    32'(err_code_o),  32'd2);
    check("to_valid",   32'(cmd_valid_o), 32'd0);
    check("to_data_held", 32'(cmd_data_o), 32'd0);
    send_frame(3'd1, 16'h0000, f0, l0);
    check("t1_valid", 32'(cmd_valid_o), 32'd1);
    check("t1_type",  32'(cmd_type_o),  32'd1);
    check("t1_data",  32'(cmd_data_o),  32'd0);

`ifdef TRAFFIC_CMD_PARSER_CHECKSUM_EN
    // Raw checksum frames: good then corrupted trailing byte.
    send_byte(8'hA5, a0); send_byte(8'h00, a0); send_byte(8'h03, a0); send_byte(8'hA6, a0);
    check("cs_valid", 32'(cmd_valid_o), 32'd1);
    check("cs_type",  32'(cmd_type_o),  32'd5);
    check("cs_data",  32'(cmd_data_o),  32'h0003);
    send_byte(8'hA5, a0); send_byte(8'h00, a0); send_byte(8'h03, a0); send_byte(8'hA7, a0);
    check("cs_bad_err",   32'(err_o),       32'd1);
    check("cs_bad_code",  32'(err_code_o),  32'd3);
    check("cs_bad_valid", 32'(cmd_valid_o), 32'd0);
`else
    send_frame(3'd5, 16'h0003, f0, l0);
    check("t5_valid", 32'(cmd_valid_o), 32'd1);
    check("t5_type",  32'(cmd_type_o),  32'd5);
    check("t5_data",  32'(cmd_data_o),  32'h0003);
`endif

    // Reset mid-frame discards the partial frame and clears outputs.
    send_byte(8'hA3, a0);
    send_byte(8'h01, a0);
    srst_i = 1'b1;
    #1;
    check("mid_rst_ready", 32'(byte_ready_o), 32'd0);
    step();
    srst_i = 1'b0;
    #1;
    check("mid_rst_valid", 32'(cmd_valid_o), 32'd0);
    check("mid_rst_type",  32'(cmd_type_o),  32'd0);
    check("mid_rst_data",  32'(cmd_data_o),  32'd0);
    check("mid_rst_ready_rel", 32'(byte_ready_o), 32'd1);
    step();
    check("mid_rst_nostrobe", 32'(cmd_valid_o), 32'd0);

    // Reset mid-gap returns straight to IDLE.
    send_frame(3'd4, 16'h1234, f0, l0);
    check("t4_data", 32'(cmd_data_o), 32'h1234);
    step();
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    #1;
    check("gap_rst_ready", 32'(byte_ready_o), 32'd1);
    check("gap_rst_data",  32'(cmd_data_o),   32'd0);

    send_frame(3'd2, 16'h0000, f0, l0);
    check("t2_valid", 32'(cmd_valid_o), 32'd1);
    check("t2_type",  32'(cmd_type_o),  32'd2);
    check("t2_data",  32'(cmd_data_o),  32'd0);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_cmd_parser.md
# traffic_cmd_parser

Byte-stream command parser sitting directly upstream of the traffic-light controller. Accepts framed command bytes over a valid/ready interface, validates sync, type and (optionally) checksum, and emits one single-cycle `cmd_type/cmd_data/cmd_valid` strobe per good frame. It paces output so successive commands are separated by a configurable gap and drops stalled or malformed frames with an error pulse.

## Interface
- `GAP_CYC`, 4: idle cycles after each issued command during which no bytes are accepted (0 allowed).
- `TIMEOUT_CYC`, 1000: max cycles between bytes inside a frame before the frame is abandoned (≥1).
- `clk_i` in 1: clock.
- `srst_i` in 1: one clock; reset is synchronous and active-high.
- `byte_i` in 8: stream byte.
- `byte_valid_i` in 1: `byte_i` valid.
- `byte_ready_o` out 1: parser can accept a byte; transfer when `byte_valid_i && byte_ready_o`.
- `cmd_type_o` out 3: command type to controller.
- `cmd_data_o` out 16: command payload (duration) to controller.
- `cmd_valid_o` out 1: one-cycle command strobe.
- `err_o` out 1: one-cycle error strobe.
- `err_code_o` out 2: 0 bad sync, 1 bad type, 2 timeout, 3 checksum; meaningful only with `err_o`.

## Operation
- Frame: header `{4'hA, 1'b0, type[2:0]}`; types 0,1,2 are short (header only, `cmd_data_o`=0); types 3,4,5 are long (header, data[15:8], data[7:0]).
- States: IDLE, DATA_HI, DATA_LO, CSUM (macro only), ISSUE, GAP.
- IDLE: accepted byte with `[7:4]!=4'hA` or `[3]!=0` -> err code 0, stay IDLE. Good sync, type 6/7 -> err code 1, stay IDLE. Short type -> ISSUE (or CSUM). Long type -> DATA_HI.
- DATA_HI -> DATA_LO -> ISSUE (or CSUM) on each accepted byte.
- ISSUE: `cmd_valid_o`=1 for exactly one cycle; then GAP if `GAP_CYC`>0, else IDLE.
- GAP: counts `GAP_CYC` cycles, then IDLE.
- `byte_ready_o`=1 in IDLE/DATA_HI/DATA_LO/CSUM, 0 in ISSUE/GAP and while `srst_i` high.
- Timeout: counter cleared on every accepted byte and on entry to DATA_HI; increments each cycle in DATA_HI/DATA_LO/CSUM without a transfer; reaching `TIMEOUT_CYC` -> err code 2, frame dropped, IDLE. Width `$clog2(TIMEOUT_CYC+1)`, saturating, never wraps.
- Transfer and timeout in the same cycle: transfer wins, counter cleared.
- `cmd_type_o`/`cmd_data_o` registered, updated only on entry to ISSUE, hold last value otherwise.
- Errors never produce `cmd_valid_o`; `err_o` and `cmd_valid_o` never high together.

## Timing
- Reset: state IDLE; `cmd_valid_o`, `err_o`, `err_code_o`, `cmd_type_o`, `cmd_data_o` all 0; counters 0.
- Reset mid-frame or mid-GAP: partial frame discarded, no strobe, IDLE next cycle.
- Latency: last frame byte accepted cycle N -> `cmd_valid_o` high cycle N+1.
- Error strobe: offending byte accepted cycle N -> `err_o` high cycle N+1; timeout detected cycle N -> `err_o` cycle N+1.
- Throughput: `byte_ready_o` low cycles N+1..N+1+`GAP_CYC`; next byte accepted no earlier than N+2+`GAP_CYC`.
- Bytes after an error: accepted from cycle N+1 (no gap after errors).

## Configuration
- `TRAFFIC_CMD_PARSER_CHECKSUM_EN` defined: every frame carries one extra trailing byte equal to XOR of all preceding frame bytes; CSUM state checks it; mismatch -> err code 3, no command, IDLE. Timeout applies in CSUM.
- Not defined: CSUM state absent; frames end after header (short) or data[7:0] (long); err code 3 never produced.

## Test plan
- Reset then byte 0xA0, valid 1 cycle -> `cmd_valid_o` one cycle later, type 0, data 0x0000; ready low for 1+`GAP_CYC` cycles.
- Long frame 0xA3,0x00,0x0A with `GAP_CYC`=4 -> strobe type 3, data 0x000A; next header accepted no earlier than 6 cycles after 0x0A accepted.
- Bytes 0x53 then 0xA7 -> two `err_o` pulses, codes 0 then 1, no `cmd_valid_o`.
- 0xA4,0x12 then idle `TIMEOUT_CYC` cycles -> `err_o` code 2; following 0xA1 issues type 1 normally.
- Checksum build: 0xA5,0x00,0x03,0xA6 -> strobe type 5 data 3; same frame with 0xA7 -> err code 3, no strobe.
- Assert `srst_i` after 0xA3,0x01 -> no strobe, outputs 0; fresh 0xA2 afterwards issues type 2.
